// File: rtl/sack_receiver_ack_gen.sv
// ============================================================================
//  Module   : sack_receiver_ack_gen
//  Purpose  : Receiver-side SACK ack generator. Tracks received sequence
//             numbers in a window bitmap and emits one CACK/SACK per packet.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sack_receiver_ack_gen #(
    parameter int SEQ_W     = 32,
    parameter int WIN_SIZE  = 128,
    parameter int WIN_IND_W = 7,
    parameter int TX_CNT_W  = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                data_valid,
    output logic                data_ready,
    input  logic [SEQ_W-1:0]    data_seq,
    input  logic [TX_CNT_W-1:0] data_tx_id,
    output logic                ack_valid,
    input  logic                ack_ready,
    output logic                ack_is_sack,
    output logic [SEQ_W-1:0]    ack_cack,
    output logic [SEQ_W-1:0]    ack_sack,
    output logic [TX_CNT_W-1:0] ack_tx_id
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADV  = 2'd1,
        ST_SEND = 2'd2
    } state_t;

    localparam logic [SEQ_W:0] C_WIN_SPAN = (SEQ_W+1)'(WIN_SIZE);

    state_t                state_q, state_d;
    logic [SEQ_W-1:0]      cack_q, cack_d;
    logic [WIN_SIZE-1:0]   bitmap_q, bitmap_d;
    logic                  ack_is_sack_q, ack_is_sack_d;
    logic [SEQ_W-1:0]      ack_cack_q, ack_cack_d;
    logic [SEQ_W-1:0]      ack_sack_q, ack_sack_d;
    logic [TX_CNT_W-1:0]   ack_tx_id_q, ack_tx_id_d;

    logic [WIN_IND_W-1:0]  w_seq_idx;
    logic [WIN_IND_W-1:0]  w_cack_idx;
    logic [WIN_IND_W-1:0]  w_next_idx;
    logic [SEQ_W:0]        w_win_end;
    logic                  w_in_win;

    // Window end is computed one bit wider so cack near the top of the seq
    // space cannot wrap the compare.
    assign w_seq_idx  = data_seq[WIN_IND_W-1:0];
    assign w_cack_idx = cack_q[WIN_IND_W-1:0];
    assign w_next_idx = w_cack_idx + WIN_IND_W'(1);
    assign w_win_end  = {1'b0, cack_q} + C_WIN_SPAN;
    assign w_in_win   = (data_seq >= cack_q) && ({1'b0, data_seq} < w_win_end);

    always_comb begin
        state_d       = state_q;
        cack_d        = cack_q;
        bitmap_d      = bitmap_q;
        ack_is_sack_d = ack_is_sack_q;
        ack_cack_d    = ack_cack_q;
        ack_sack_d    = ack_sack_q;
        ack_tx_id_d   = ack_tx_id_q;

        case (state_q)
            ST_IDLE: begin
                if (data_valid) begin
                    ack_tx_id_d = data_tx_id;
                    if (!w_in_win) begin
                        ack_is_sack_d = 1'b0;
                        ack_cack_d    = cack_q;
                        ack_sack_d    = '0;
                        state_d       = ST_SEND;
                    end else if (data_seq == cack_q) begin
                        bitmap_d[w_seq_idx] = 1'b1;
                        state_d             = ST_ADV;
                    end else begin
                        bitmap_d[w_seq_idx] = 1'b1;
                        ack_is_sack_d       = 1'b1;
                        ack_cack_d          = cack_q;
                        ack_sack_d          = data_seq;
                        state_d             = ST_SEND;
                    end
                end
            end
            ST_ADV: begin
                // Slide the window by one; stop at the first hole.
                bitmap_d[w_cack_idx] = 1'b0;
                cack_d               = cack_q + SEQ_W'(1);
                if (!bitmap_q[w_next_idx]) begin
                    ack_is_sack_d = 1'b0;
                    ack_cack_d    = cack_q + SEQ_W'(1);
                    ack_sack_d    = '0;
                    state_d       = ST_SEND;
                end
            end
            ST_SEND: begin
                if (ack_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            cack_q        <= '0;
            bitmap_q      <= '0;
            ack_is_sack_q <= 1'b0;
            ack_cack_q    <= '0;
            ack_sack_q    <= '0;
            ack_tx_id_q   <= '0;
        end else begin
            state_q       <= state_d;
            cack_q        <= cack_d;
            bitmap_q      <= bitmap_d;
            ack_is_sack_q <= ack_is_sack_d;
            ack_cack_q    <= ack_cack_d;
            ack_sack_q    <= ack_sack_d;
            ack_tx_id_q   <= ack_tx_id_d;
        end
    end

    assign data_ready  = (state_q == ST_IDLE) && !rst;
    assign ack_valid   = (state_q == ST_SEND);
    assign ack_is_sack = ack_is_sack_q;
    assign ack_cack    = ack_cack_q;
    assign ack_sack    = ack_sack_q;
    assign ack_tx_id   = ack_tx_id_q;

endmodule

`default_nettype wire

// File: tb/tb_sack_receiver_ack_gen.sv
// ============================================================================
//  Module   : tb_sack_receiver_ack_gen
//  Purpose  : Self-checking bench for sack_receiver_ack_gen (vector table,
//             directed corner sequences, randomized traffic vs. set model).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sack_receiver_ack_gen;

    localparam int SEQ_W    = 32;
    localparam int WIN_SIZE = 128;
    localparam int TX_CNT_W = 2;

    logic                clk;
    logic                rst;
    logic                data_valid;
    logic                data_ready;
    logic [SEQ_W-1:0]    data_seq;
    logic [TX_CNT_W-1:0] data_tx_id;
    logic                ack_valid;
    logic                ack_ready;
    logic                ack_is_sack;
    logic [SEQ_W-1:0]    ack_cack;
    logic [SEQ_W-1:0]    ack_sack;
    logic [TX_CNT_W-1:0] ack_tx_id;

    int n_cmp = 0;
    int n_bad = 0;

    sack_receiver_ack_gen #(
        .SEQ_W    (SEQ_W),
        .WIN_SIZE (WIN_SIZE),
        .WIN_IND_W(7),
        .TX_CNT_W (TX_CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .data_seq   (data_seq),
        .data_tx_id (data_tx_id),
        .ack_valid  (ack_valid),
        .ack_ready  (ack_ready),
        .ack_is_sack(ack_is_sack),
        .ack_cack   (ack_cack),
        .ack_sack   (ack_sack),
        .ack_tx_id  (ack_tx_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference model: cumulative ack plus the set of buffered seqs above it.
    longint   m_cack;
    bit       m_held[longint];

    task automatic model_pkt(input longint s, output bit e_sack, output longint e_cack,
                             output longint e_sel, output int e_lat);
        e_sack = 1'b0;
        e_sel  = 0;
        e_lat  = 1;
        if (s < m_cack || s >= m_cack + WIN_SIZE) begin
            e_cack = m_cack;
        end else if (s == m_cack) begin
            m_held[s] = 1'b1;
            while (m_held.exists(m_cack)) begin
                m_held.delete(m_cack);
                m_cack++;
                e_lat++;
            end
            e_cack = m_cack;
        end else begin
            m_held[s] = 1'b1;
            e_sack = 1'b1;
            e_cack = m_cack;
            e_sel  = s;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst_ack_valid", ack_valid, 0);
        chk("rst_data_ready", data_ready, 0);
        @(negedge clk);
        rst = 1'b0;
        m_cack = 0;
        m_held.delete();
    endtask

    // Send one packet, wait for its ack, hold ack_ready low for 'hold' cycles,
    // then complete a single handshake. Latency counts edges from accept edge.
    task automatic send_pkt(input longint s, input logic [TX_CNT_W-1:0] tx, input int hold,
                            input bit e_sack, input longint e_cack, input longint e_sel,
                            input int e_lat, input string tag);
        int lat;
        logic              r_sack;
        logic [SEQ_W-1:0]  r_cack, r_sel;
        logic [TX_CNT_W-1:0] r_tx;
        @(negedge clk);
        chk({tag, "_ready_idle"}, data_ready, 1);
        data_valid = 1'b1;
        data_seq   = SEQ_W'(s);
        data_tx_id = tx;
        @(posedge clk);
        #1;
        data_valid = 1'b0;
        lat = 1;
        while (!ack_valid && lat < 300) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk({tag, "_latency"}, lat, e_lat);
        chk({tag, "_is_sack"}, ack_is_sack, e_sack);
        chk({tag, "_cack"}, ack_cack, e_cack);
        chk({tag, "_sack"}, ack_sack, e_sel);
        chk({tag, "_tx_id"}, ack_tx_id, tx);
        r_sack = ack_is_sack; r_cack = ack_cack; r_sel = ack_sack; r_tx = ack_tx_id;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            if (ack_valid !== 1'b1 || ack_is_sack !== r_sack || ack_cack !== r_cack ||
                ack_sack !== r_sel || ack_tx_id !== r_tx || data_ready !== 1'b0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL %s_hold cycle %0d: valid=%0b rdy=%0b cack=%0d sack=%0d required stable valid=1 rdy=0",
                         tag, i, ack_valid, data_ready, ack_cack, ack_sack);
            end else begin
                n_cmp++;
            end
        end
        @(negedge clk);
        ack_ready = 1'b1;
        @(posedge clk);
        #1;
        ack_ready = 1'b0;
        chk({tag, "_valid_drop"}, ack_valid, 0);
    endtask

    typedef struct {
        bit              do_rst;
        longint          seq;
        logic [1:0]      tx;
        bit              e_sack;
        longint          e_cack;
        longint          e_sel;
        int              e_lat;
    } vec_t;

    vec_t vecs[14];

    initial begin
        bit     rs;
        longint rc, rsel, s;
        int     rl;

        rst = 1'b1; data_valid = 1'b0; data_seq = '0; data_tx_id = '0; ack_ready = 1'b0;
        m_cack = 0;
        #1;
        chk("async_rst_valid", ack_valid, 0);
        chk("async_rst_ready", data_ready, 0);
        repeat (2) @(negedge clk);
        chk("rst_is_sack", ack_is_sack, 0);
        chk("rst_cack", ack_cack, 0);
        chk("rst_sack", ack_sack, 0);
        chk("rst_tx_id", ack_tx_id, 0);
        rst = 1'b0;
        #1;
        chk("post_rst_ready", data_ready, 1);

        vecs = '{
            '{1'b0, 0,   2'd1, 1'b0, 1, 0,   2},
            '{1'b0, 2,   2'd2, 1'b1, 1, 2,   1},
            '{1'b0, 3,   2'd3, 1'b1, 1, 3,   1},
            '{1'b0, 3,   2'd0, 1'b1, 1, 3,   1},
            '{1'b0, 1,   2'd2, 1'b0, 4, 0,   4},
            '{1'b0, 0,   2'd3, 1'b0, 4, 0,   1},
            '{1'b0, 132, 2'd1, 1'b0, 4, 0,   1},
            '{1'b0, 131, 2'd2, 1'b1, 4, 131, 1},
            '{1'b0, 4,   2'd3, 1'b0, 5, 0,   2},
            '{1'b1, 0,   2'd2, 1'b0, 1, 0,   2},
            '{1'b0, 0,   2'd1, 1'b0, 1, 0,   1},
            '{1'b1, 128, 2'd3, 1'b0, 0, 0,   1},
            '{1'b0, 127, 2'd1, 1'b1, 0, 127, 1},
            '{1'b0, 0,   2'd0, 1'b0, 1, 0,   2}
        };
        for (int i = 0; i < 14; i++) begin
            if (vecs[i].do_rst) do_reset();
            send_pkt(vecs[i].seq, vecs[i].tx, (i == 2) ? 5 : 0, vecs[i].e_sack,
                     vecs[i].e_cack, vecs[i].e_sel, vecs[i].e_lat, $sformatf("vec%0d", i));
        end

        // Reset during the advance walk must discard everything.
        do_reset();
        for (int k = 1; k <= 5; k++) send_pkt(k, 2'(k), 0, 1'b1, 0, k, 1, "buf");
        @(negedge clk);
        data_valid = 1'b1; data_seq = '0; data_tx_id = 2'd3;
        @(posedge clk);
        #1;
        data_valid = 1'b0;
        @(posedge clk);
        #2;
        chk("adv_no_valid", ack_valid, 0);
        rst = 1'b1;
        #1;
        chk("midrst_valid", ack_valid, 0);
        chk("midrst_ready", data_ready, 0);
        chk("midrst_cack", ack_cack, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("midrst_ready_after", data_ready, 1);
        m_cack = 0;
        m_held.delete();
        send_pkt(0, 2'd1, 0, 1'b0, 1, 0, 2, "after_midrst");
        m_cack = 1;

        // Randomized traffic against the set model.
        for (int i = 0; i < 400; i++) begin
            longint lo;
            lo = (m_cack > 6) ? m_cack - 6 : 0;
            if ($urandom_range(0, 3) == 0) s = m_cack;
            else s = lo + longint'($urandom_range(0, 145));
            model_pkt(s, rs, rc, rsel, rl);
            send_pkt(s, 2'($urandom_range(0, 3)), int'($urandom_range(0, 2)), rs, rc, rsel, rl,
                     $sformatf("rnd%0d", i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
